// File: rtl/tx_arb_pkg.sv
// tx_arb_pkg: shared types and constants for the UART transmit arbiter.
// Holds the arbiter FSM state type and the byte parked on the transmitter
// data input whenever no requester has been granted.
package tx_arb_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SEND  = 2'd1,
    DRAIN = 2'd2
  } arbState_t;

  localparam logic [7:0] TX_IDLE_BYTE = 8'hFF;

endpackage

// File: rtl/tx_arbiter_rr_pick.sv
// rr_pick: combinational winner selection for the transmit arbiter.
// Starting at ptr and wrapping modulo N, the first asserted request wins.
// Driving ptr with zero turns this into a lowest-index-first priority picker.
module rr_pick #(
  parameter int N   = 4,
  parameter int IDW = $clog2(N)
) (
  input  logic [N-1:0]   req,
  input  logic [IDW-1:0] ptr,
  output logic           valid,
  output logic [IDW-1:0] winner
);

  // Walk the N positions from ptr onward and keep the first requester found
  always_comb begin
    int   idx;
    logic found;
    valid  = |req;
    winner = '0;
    found  = 1'b0;
    idx    = 0;
    for (int k = 0; k < N; k++) begin
      idx = (int'(ptr) + k) % N;
      if (!found && req[idx]) begin
        winner = IDW'(idx);
        found  = 1'b1;
      end
    end
  end

endmodule

// File: rtl/tx_arbiter.sv
// tx_arbiter: shares one UART transmitter among N byte requesters.
// A winner is chosen only while idle; its byte is latched onto txDin and held
// for the whole frame while the Send/Sent four-phase handshake runs
// (SEND waits for Sent to rise, DRAIN waits for it to fall).
// Build option: define TX_ARB_FIXED_PRI_EN for fixed lowest-index priority;
// by default the grant rotates round-robin.
module tx_arbiter
  import tx_arb_pkg::*;
#(
  parameter int N   = 4,
  parameter int IDW = $clog2(N)
) (
  input  logic           clk,
  input  logic           Reset,
  input  logic [N-1:0]   req,
  input  logic [8*N-1:0] data,
  output logic [N-1:0]   ack,
  output logic           busy,
  output logic [IDW-1:0] grantId,
  output logic           txSend,
  output logic [7:0]     txDin,
  input  logic           txSent
);

  arbState_t      state;
  arbState_t      state_next;
  logic           pick_valid;
  logic [IDW-1:0] pick_winner;
  logic [IDW-1:0] pick_ptr;
  logic           grant;

  // A grant happens only from IDLE; requests during a frame simply wait
  assign grant = (state == IDLE) && pick_valid;

`ifdef TX_ARB_FIXED_PRI_EN
  assign pick_ptr = '0;
`else
  logic [IDW-1:0] rr_ptr;

  // Move the search start just past each winner so it gets lowest priority next
  always_ff @(posedge clk) begin
    if (Reset) begin
      rr_ptr <= '0;
    end else if (grant) begin
      rr_ptr <= (pick_winner == IDW'(N-1)) ? '0 : pick_winner + 1'b1;
    end
  end

  assign pick_ptr = rr_ptr;
`endif

  rr_pick #(
    .N   (N),
    .IDW (IDW)
  ) u_pick (
    .req    (req),
    .ptr    (pick_ptr),
    .valid  (pick_valid),
    .winner (pick_winner)
  );

  // Handshake state register
  always_ff @(posedge clk) begin
    if (Reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic for the Send/Sent four-phase handshake
  always_comb begin
    state_next = IDLE;
    case (state)
      IDLE:    state_next = pick_valid ? SEND : IDLE;
      SEND:    state_next = txSent ? DRAIN : SEND;
      DRAIN:   state_next = txSent ? DRAIN : IDLE;
      default: state_next = IDLE;
    endcase
  end

  assign txSend = (state == SEND);
  assign busy   = (state != IDLE);

  // Latch the winner's byte and identity, and pulse its ack for one cycle
  always_ff @(posedge clk) begin
    if (Reset) begin
      ack     <= '0;
      grantId <= '0;
      txDin   <= TX_IDLE_BYTE;
    end else begin
      ack <= '0;
      if (grant) begin
        ack[pick_winner] <= 1'b1;
        grantId          <= pick_winner;
        txDin            <= data[{pick_winner, 3'b000} +: 8];
      end
    end
  end

endmodule

// File: tb/tb_tx_arbiter.sv
// tb_tx_arbiter: directed bench for tx_arbiter with a small UART transmitter
// stand-in (4 clocks per bit, odd parity) and an ownership-level reference model.
// Define TX_ARB_FIXED_PRI_EN to check the fixed-priority build.
module tb_tx_arbiter;

  localparam int N   = 4;
  localparam int IDW = 2;

  logic           clk   = 1'b0;
  logic           Reset = 1'b1;
  logic [N-1:0]   req   = '0;
  logic [8*N-1:0] data  = '0;
  logic [N-1:0]   ack;
  logic           busy;
  logic [IDW-1:0] grantId;
  logic           txSend;
  logic [7:0]     txDin;
  logic           txSent = 1'b0;

  int nCompared = 0;
  int nMismatch = 0;

  always #5 clk = ~clk;

  tx_arbiter #(.N(N), .IDW(IDW)) dut (
    .clk     (clk),
    .Reset   (Reset),
    .req     (req),
    .data    (data),
    .ack     (ack),
    .busy    (busy),
    .grantId (grantId),
    .txSend  (txSend),
    .txDin   (txDin),
    .txSent  (txSent)
  );

  // Transmitter stand-in: start, 8 data bits LSB first, odd parity, stop
  logic       txActive = 1'b0;
  logic [3:0] bitNum   = '0;
  logic [1:0] bitCnt   = '0;
  logic [10:0] frame;
  logic       sout;

  assign frame = {1'b1, ~^txDin, txDin, 1'b0};
  assign sout  = txActive ? frame[bitNum] : 1'b1;

  always @(posedge clk) begin
    if (Reset) begin
      txActive <= 1'b0;
      txSent   <= 1'b0;
      bitNum   <= '0;
      bitCnt   <= '0;
    end else if (!txActive && !txSent && txSend) begin
      txActive <= 1'b1;
      bitNum   <= '0;
      bitCnt   <= '0;
    end else if (txActive) begin
      if (bitCnt == 2'd3) begin
        bitCnt <= '0;
        if (bitNum == 4'd10) begin
          txActive <= 1'b0;
          txSent   <= 1'b1;
        end else begin
          bitNum <= bitNum + 4'd1;
        end
      end else begin
        bitCnt <= bitCnt + 2'd1;
      end
    end else if (txSent && !txSend) begin
      txSent <= 1'b0;
    end
  end

  // Reference model: who owns the transmitter and whether Sent has been seen
  bit         mOwned    = 1'b0;
  bit         mDraining = 1'b0;
  int         mPtr      = 0;
  int         mGrant    = 0;
  logic [7:0] mDin      = 8'hFF;
  logic [3:0] mAck      = '0;

  function automatic int pickWinner(input logic [3:0] r, input int start);
    for (int off = 0; off < N; off++) begin
      if (r[(start + off) % N]) return (start + off) % N;
    end
    return -1;
  endfunction

  always @(posedge clk) begin : model
    int w;
    if (Reset) begin
      mOwned = 0; mDraining = 0; mPtr = 0; mGrant = 0; mDin = 8'hFF; mAck = '0;
    end else begin
      mAck = '0;
      if (!mOwned) begin
        if (req != 0) begin
`ifdef TX_ARB_FIXED_PRI_EN
          w = pickWinner(req, 0);
`else
          w = pickWinner(req, mPtr);
          mPtr = (w + 1) % N;
`endif
          mGrant    = w;
          mDin      = data[8*w +: 8];
          mAck[w]   = 1'b1;
          mOwned    = 1;
          mDraining = 0;
        end
      end else if (!mDraining) begin
        if (txSent) mDraining = 1;
      end else if (!txSent) begin
        mOwned    = 0;
        mDraining = 0;
      end
    end
  end

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    nCompared++;
    if (actual !== expected) begin
      nMismatch++;
      $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, actual, expected, $time);
    end
  endtask

  // Every cycle: DUT outputs against the model; log grants and frame bits
  bit checkEn = 1'b0;
  int grantLog[$];
  logic soutLog[$];

  always @(negedge clk) begin
    if (checkEn) begin
      checkOutput("ack", 32'(ack), 32'(mAck));
      checkOutput("busy", 32'(busy), 32'(mOwned));
      checkOutput("txSend", 32'(txSend), 32'(mOwned && !mDraining));
      checkOutput("txDin", 32'(txDin), 32'(mDin));
      checkOutput("grantId", 32'(grantId), 32'(mGrant));
      if (ack != 0) grantLog.push_back(int'(grantId));
    end
    if (txActive && bitCnt == 2'd2) soutLog.push_back(sout);
  end

  task automatic applyStimulus(input logic [3:0] r, input logic [31:0] d);
    @(negedge clk);
    req  = r;
    data = d;
  endtask

  task automatic timeoutFail(input string name);
    nCompared++;
    nMismatch++;
    $display("[TB] FAIL %s: wait expired, expected event did not occur", name);
  endtask

  task automatic waitAck(input int limit);
    for (int i = 0; i < limit; i++) begin
      @(negedge clk);
      if (ack != 0) return;
    end
    timeoutFail("waitAck");
  endtask

  task automatic waitIdle(input int limit);
    for (int i = 0; i < limit; i++) begin
      @(negedge clk);
      if (!busy) return;
    end
    timeoutFail("waitIdle");
  endtask

  task automatic pulseReset();
    @(negedge clk);
    Reset = 1'b1;
    req   = '0;
    repeat (2) @(negedge clk);
    Reset = 1'b0;
  endtask

  task automatic checkGrants(input string name, input int exp[$]);
    checkOutput({name, " count"}, 32'(grantLog.size()), 32'(exp.size()));
    if (grantLog.size() == exp.size()) begin
      for (int i = 0; i < exp.size(); i++)
        checkOutput($sformatf("%s[%0d]", name, i), 32'(grantLog[i]), 32'(exp[i]));
    end
  endtask

  initial begin
    int expBits[11];
    expBits = '{0, 1, 0, 0, 0, 0, 0, 1, 0, 1, 1};

    repeat (2) @(negedge clk);
    checkEn = 1'b1;
    Reset   = 1'b0;

    $display("[TB] idle after reset");
    applyStimulus(4'b0000, 32'h0);
    repeat (20) @(negedge clk);
    checkOutput("idle txSend", 32'(txSend), 32'd0);
    checkOutput("idle busy", 32'(busy), 32'd0);
    checkOutput("idle ack", 32'(ack), 32'd0);
    checkOutput("idle txDin", 32'(txDin), 32'hFF);

    $display("[TB] single requester 2, byte 41");
    soutLog.delete();
    applyStimulus(4'b0100, 32'h0041_0000);
    @(negedge clk);
    checkOutput("single ack", 32'(ack), 32'b0100);
    checkOutput("single txSend", 32'(txSend), 32'd1);
    checkOutput("single txDin", 32'(txDin), 32'h41);
    checkOutput("single grantId", 32'(grantId), 32'd2);
    req = '0;
    waitIdle(400);
    checkOutput("frame length", 32'(soutLog.size()), 32'd11);
    if (soutLog.size() == 11) begin
      for (int i = 0; i < 11; i++)
        checkOutput($sformatf("frame bit %0d", i), 32'(soutLog[i]), 32'(expBits[i]));
    end

    $display("[TB] all four requesting");
    pulseReset();
    grantLog.delete();
    applyStimulus(4'b1111, 32'h1312_1110);
    for (int g = 0; g < 5; g++) waitAck(300);
    checkOutput("fifth grant txDin", 32'(txDin), 32'h10);
    req = '0;
    waitIdle(400);
`ifdef TX_ARB_FIXED_PRI_EN
    checkGrants("order", '{0, 0, 0, 0, 0});
`else
    checkGrants("order", '{0, 1, 2, 3, 0});
`endif

    $display("[TB] short pulse on requester 3 during a frame");
    pulseReset();
    grantLog.delete();
    applyStimulus(4'b0010, 32'h0000_2200);
    waitAck(20);
    req = '0;
    repeat (5) @(negedge clk);
    req = 4'b1000;
    @(negedge clk);
    req = '0;
    waitIdle(400);
    applyStimulus(4'b0100, 32'h0033_0000);
    waitAck(20);
    req = '0;
    waitIdle(400);
    checkGrants("pulse", '{1, 2});

    $display("[TB] reset in the middle of a frame");
    applyStimulus(4'b0100, 32'h00A5_0000);
    waitAck(20);
    req = '0;
    for (int i = 0; i <= 200; i++) begin
      @(negedge clk);
      if (txActive && bitNum == 4'd4) break;
      if (i == 200) timeoutFail("wait data bit 4");
    end
    Reset = 1'b1;
    @(negedge clk);
    checkOutput("rst txSend", 32'(txSend), 32'd0);
    checkOutput("rst busy", 32'(busy), 32'd0);
    checkOutput("rst grantId", 32'(grantId), 32'd0);
    checkOutput("rst txDin", 32'(txDin), 32'hFF);
    checkOutput("rst sout", 32'(sout), 32'd1);
    Reset = 1'b0;
    grantLog.delete();
    applyStimulus(4'b0110, 32'h0055_4400);
    waitAck(20);
    req = 4'b0100;
    waitAck(400);
    req = '0;
    waitIdle(400);
    checkGrants("after reset", '{1, 2});

    $display("[TB] pointer wrap from requester 3");
    pulseReset();
    grantLog.delete();
    applyStimulus(4'b1000, 32'h7700_0066);
    waitAck(20);
    req = 4'b1001;
    waitAck(400);
    req = '0;
    waitIdle(400);
    checkGrants("wrap", '{3, 0});

    repeat (3) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatch);
    $finish;
  end

  initial begin
    #300000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
